// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver.
//   scan_state_e : scan FSM states
//   NUM_DIGITS   : number of multiplexed digits
//   DIG_*        : digit-index constants, in anode order
//   SEG_OFF      : all segment cathodes off (active-low)
//   AN_OFF       : all digit anodes off (active-low)
//   an_select()  : active-low one-cold anode vector for a digit index
package seg_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_ON,
        S_BLANK
    } scan_state_e;

    localparam int unsigned NUM_DIGITS = 6;

    localparam logic [2:0] DIG_HRL_M = 3'd0;
    localparam logic [2:0] DIG_HRL_L = 3'd1;
    localparam logic [2:0] DIG_MIN_M = 3'd2;
    localparam logic [2:0] DIG_MIN_L = 3'd3;
    localparam logic [2:0] DIG_SEC_M = 3'd4;
    localparam logic [2:0] DIG_SEC_L = 3'd5;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [5:0] AN_OFF  = 6'h3F;

    function automatic logic [5:0] an_select(input logic [2:0] digit);
        logic [5:0] one_hot;
        one_hot = 6'b000001 << digit;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter shared by the on and blank phases of the scan FSM.
//   clk      : system clock
//   rst      : synchronous active-high reset (count to 0)
//   clear    : synchronous clear (count to 0), priority over load
//   load     : load load_val this cycle
//   load_val : value to load; phase lasts load_val+1 cycles
//   done     : count is zero (last cycle of the current phase)
module scan_timer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment scan driver with blinking colon.
// Each frame: one load cycle that snapshots all digit inputs, then for each
// digit DWELL on-cycles followed by BLANK all-off cycles.
//   clk, rst          : clock, synchronous active-high reset
//   en                : scan enable; low blanks the display and restarts
//   HRL_M .. SEC_L    : digit patterns, bit0..bit6 = segments a..g, 1 = lit
//   an                : digit anodes, active-low, an[0] = HRL_M
//   seg               : segment cathodes, active-low
//   dp                : colon / decimal point, active-low
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned DWELL        = 1000,
    parameter int unsigned BLANK        = 50,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] HRL_M,
    input  logic [6:0] HRL_L,
    input  logic [6:0] MIN_M,
    input  logic [6:0] MIN_L,
    input  logic [6:0] SEC_M,
    input  logic [6:0] SEC_L,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned MAX_CNT  = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned TW       = $clog2(MAX_CNT + 1);
    localparam int unsigned FW       = $clog2((BLINK_FRAMES > 1) ? BLINK_FRAMES : 2);
    localparam bit          HasBlank = (BLANK != 0);

    localparam logic [TW-1:0] DWELL_LD   = TW'(DWELL - 1);
    localparam logic [TW-1:0] BLANK_LD   = TW'((BLANK == 0) ? 0 : BLANK - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    scan_state_e                   state_q;
    logic [2:0]                    digit_q;
    logic [FW-1:0]                 frame_q;
    logic                          colon_on_q;
    // Colon value captured with the digit snapshot so a frame never changes
    // its colon state part way through.
    logic                          colon_shadow_q;
    logic [NUM_DIGITS-1:0][6:0]    shadow_q;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    // Timer reloads whenever the FSM enters an on or blank phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = DWELL_LD;
        unique case (state_q)
            S_LOAD: tmr_load = 1'b1;
            S_ON: begin
                if (tmr_done) begin
                    if (HasBlank) begin
                        tmr_load = 1'b1;
                        tmr_val  = BLANK_LD;
                    end else if (digit_q != DIG_SEC_L) begin
                        tmr_load = 1'b1;
                    end
                end
            end
            S_BLANK: begin
                if (tmr_done && digit_q != DIG_SEC_L) begin
                    tmr_load = 1'b1;
                end
            end
            default: tmr_load = 1'b0;
        endcase
    end

    scan_timer #(
        .WIDTH (TW)
    ) u_scan_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (~en),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_LOAD;
            digit_q        <= '0;
            frame_q        <= '0;
            colon_on_q     <= 1'b1;
            colon_shadow_q <= 1'b1;
            shadow_q       <= '0;
            an             <= AN_OFF;
            seg            <= SEG_OFF;
            dp             <= 1'b1;
        end else if (!en) begin
            // Colon phase and shadow registers are left untouched.
            state_q <= S_LOAD;
            digit_q <= '0;
            frame_q <= '0;
            an      <= AN_OFF;
            seg     <= SEG_OFF;
            dp      <= 1'b1;
        end else begin
            // Outputs reflect the current state, giving one cycle of latency.
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
            if (state_q == S_ON) begin
                an  <= an_select(digit_q);
                seg <= ~shadow_q[digit_q];
                dp  <= ~(colon_shadow_q && (digit_q == DIG_HRL_L || digit_q == DIG_MIN_L));
            end

            unique case (state_q)
                S_LOAD: begin
                    shadow_q       <= {SEC_L, SEC_M, MIN_L, MIN_M, HRL_L, HRL_M};
                    colon_shadow_q <= colon_on_q;
                    digit_q        <= '0;
                    if (frame_q == FRAME_LAST) begin
                        frame_q    <= '0;
                        colon_on_q <= ~colon_on_q;
                    end else begin
                        frame_q <= frame_q + 1'b1;
                    end
                    state_q <= S_ON;
                end
                S_ON: begin
                    if (tmr_done) begin
                        if (HasBlank) begin
                            state_q <= S_BLANK;
                        end else if (digit_q == DIG_SEC_L) begin
                            state_q <= S_LOAD;
                        end else begin
                            digit_q <= digit_q + 1'b1;
                        end
                    end
                end
                S_BLANK: begin
                    if (tmr_done) begin
                        if (digit_q == DIG_SEC_L) begin
                            state_q <= S_LOAD;
                        end else begin
                            digit_q <= digit_q + 1'b1;
                            state_q <= S_ON;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DWELL, default 1000: cycles each digit is driven, minimum 1.
REQ-002 Parameter BLANK, default 50: all-off cycles after each digit, minimum 0.
REQ-003 Parameter BLINK_FRAMES, default 64: frames per colon half-period, minimum 1.
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  scan enable; 0 blanks the display.
REQ-007 HRL_M, HRL_L, MIN_M, MIN_L, SEC_M, SEC_L  in  7 each  digit patterns; bit0..bit6 = segments a..g; 1 = lit.
REQ-008 an  out  6  digit anodes, active-low; an[0]=HRL_M ... an[5]=SEC_L, in that order.
REQ-009 seg  out  7  segment cathodes, active-low; seg = ~pattern of the selected digit.
REQ-010 dp  out  1  decimal point / colon, active-low.

Function
REQ-011 FSM states: S_LOAD, S_ON, S_BLANK.
REQ-012 S_LOAD lasts 1 cycle:
- snapshot all six inputs into shadow registers
- set digit index to 0
- advance frame counter
- go to S_ON.
REQ-013 Shadow registers change only in S_LOAD, so no frame mixes two input sets.
REQ-014 S_ON lasts exactly DWELL cycles:
- an has only bit[digit] low
- seg = ~shadow[digit].
REQ-015 S_BLANK lasts exactly BLANK cycles with an=6'b111111, seg=7'h7F, dp=1.
REQ-016 BLANK=0: S_ON goes directly to the next digit's S_ON, or to S_LOAD after digit 5.
REQ-017 After digit 5's S_BLANK, the FSM returns to S_LOAD.
REQ-018 Frame period = 1 + 6*(DWELL+BLANK) cycles; outputs are all-off during S_LOAD.
REQ-019 Frame counter counts 0..BLINK_FRAMES-1 and wraps.
- On wrap, colon_on toggles.
- colon_on is 1 after reset.
REQ-020 dp = 0 only in S_ON on digit 1 (HRL_L) or digit 3 (MIN_L) while colon_on=1; otherwise dp = 1.
REQ-021 Outputs are registered: a state or digit change appears on an/seg/dp 1 cycle later, with uniform latency for all outputs.
REQ-022 en=0, in any state:
- next cycle: outputs all-off, FSM forced to S_LOAD
- dwell counter, digit index and frame counter held at 0
- colon_on held.
REQ-023 en 0->1: the first cycle is S_LOAD, then a full frame from digit 0.
REQ-024 en=0 overrides an in-progress S_ON; no partial-dwell resumption.
REQ-025 At most one an bit is low in any cycle.

Reset
REQ-026 While rst=1 at a clock edge, the following apply next cycle:
- an=6'b111111, seg=7'h7F, dp=1
- FSM=S_LOAD, digit=0, dwell counter=0, frame counter=0, colon_on=1
- shadow registers=0.
REQ-027 rst has priority over en.
REQ-028 rst mid-frame aborts the frame; the first frame after release starts with S_LOAD.

Structure
REQ-029 Shared package seg_pkg holds:
- state enum (S_LOAD, S_ON, S_BLANK)
- NUM_DIGITS=6
- digit-index constants
- SEG_OFF=7'h7F and AN_OFF=6'h3F.
REQ-030 One sub-module, scan_timer:
- loadable down-counter with done flag
- instantiated once
- shared by S_ON (loads DWELL-1) and S_BLANK (loads BLANK-1).
REQ-031 Counter widths derive from parameters via $clog2; no truncation at parameter maxima.

Verification (DWELL=4, BLANK=2, BLINK_FRAMES=2)
REQ-032 Reset:
- Stimulus: rst=1 for 2 cycles, then rst=0, en=1.
- Required: an=3F, seg=7F, dp=1 during reset; first an=3E (digit 0) appears 2 cycles after release.
REQ-033 Scan order:
- Stimulus: inputs HRL_M=7'h06 ... SEC_L=7'h3F.
- Required: an steps 3E,3D,3B,37,2F,1F; each low for 4 cycles, separated by 2 all-off cycles; seg=~input; frame period 37 cycles.
REQ-034 Coherence:
- Stimulus: change MIN_L mid-frame while digit 1 is on.
- Required: digit 3 shows the old value that frame and the new value the next frame.
REQ-035 Colon:
- Required: dp=0 during digit 1 and digit 3 on-windows in frames 0-1, dp=1 in frames 2-3, repeating.
REQ-036 Enable drop:
- Stimulus: en=0 during digit 2 S_ON, then en=1 5 cycles later.
- Required: all-off the cycle after en=0, then 1 S_LOAD cycle, then digit 0 again.
REQ-037 Mid-frame reset and BLANK=0:
- Stimulus: rst during digit 4; rerun with BLANK=0.
- Required: restart at digit 0 with colon_on=1; with BLANK=0, consecutive digits are back-to-back with no all-off gap and the frame period is 25 cycles.
